sram_req_arbiter: RTL and testbench

Single-clock request arbiter between two SRAM writers (background image writer, overlay writer) and two SRAM readers (display reader, auxiliary reader) and the ZBT SRAM controller. It sits in the SRAM clock domain behind the per-requester clock-crossing FIFOs. It issues one request per accepted handshake into a registered output stage. It tracks outstanding reads in a tag FIFO so that returned data is routed to the reader that issued it. Reader 0 (display) has priority, bounded by a burst limit; the other three requesters share the remaining slots round-robin.

---
 rtl/sram_req_arbiter.sv | 249 ++++++++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Request arbiter between two SRAM writers, two SRAM readers and the ZBT
// SRAM controller. Reader 0 (display) has burst-limited priority; w0, w1 and
// r1 share the remaining slots round-robin. A tag FIFO records the reader id
// of each outstanding read so returned words reach the reader that asked.
module sram_req_arbiter #(
    parameter int unsigned TAG_DEPTH = 8,
    parameter int unsigned R0_BURST  = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        w0_valid,
    output logic        w0_ready,
    input  logic [53:0] w0_din,

    input  logic        w1_valid,
    output logic        w1_ready,
    input  logic [53:0] w1_din,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [17:0] r0_addr,
    output logic        r0_dout_valid,
    output logic [31:0] r0_dout,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [17:0] r1_addr,
    output logic        r1_dout_valid,
    output logic [31:0] r1_dout,

    output logic        sram_addr_valid,
    input  logic        sram_ready,
    output logic [17:0] sram_addr,
    output logic [31:0] sram_data_in,
    output logic [3:0]  sram_write_mask,
    input  logic [31:0] sram_data_out,
    input  logic        sram_data_out_valid,

    output logic        err
);

    localparam int unsigned AW = $clog2(TAG_DEPTH);
    localparam int unsigned BW = $clog2(R0_BURST + 1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(TAG_DEPTH);
    localparam logic [BW-1:0] BURST_L = BW'(R0_BURST);

    typedef enum logic [1:0] {
        RR_W0 = 2'd0,
        RR_W1 = 2'd1,
        RR_R1 = 2'd2
    } rr_e;

    // Output stage
    logic        out_valid_q, out_valid_d;
    logic [17:0] out_addr_q,  out_addr_d;
    logic [31:0] out_data_q,  out_data_d;
    logic [3:0]  out_mask_q,  out_mask_d;

    // Tag FIFO (0 = reader 0, 1 = reader 1)
    logic [TAG_DEPTH-1:0] tag_mem_q;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q,  count_d;

    // Arbitration state
    logic [BW-1:0] burst_q, burst_d;
    rr_e           rr_q,    rr_d;

    // Return path
    logic        r0_dv_q, r0_dv_d;
    logic        r1_dv_q, r1_dv_d;
    logic [31:0] r0_dout_q, r0_dout_d;
    logic [31:0] r1_dout_q, r1_dout_d;
    logic        err_q, err_d;

    logic load_en;
    logic pop;
    logic pop_tag;
    logic tag_free;
    logic push;
    logic others_valid;
    logic elig_w0, elig_w1, elig_r0, elig_r1;
    logic gnt_w0, gnt_w1, gnt_r0, gnt_r1;

    assign load_en      = !out_valid_q || sram_ready;
    assign pop          = sram_data_out_valid && (count_q != '0);
    assign pop_tag      = tag_mem_q[rd_ptr_q];
    // A pop in the same cycle frees a slot for a new read even when full.
    assign tag_free     = (count_q != DEPTH_L) || pop;
    assign push         = gnt_r0 || gnt_r1;
    assign others_valid = w0_valid || w1_valid || r1_valid;

    assign elig_w0 = w0_valid;
    assign elig_w1 = w1_valid;
    assign elig_r0 = r0_valid && tag_free;
    assign elig_r1 = r1_valid && tag_free;

    assign w0_ready = gnt_w0;
    assign w1_ready = gnt_w1;
    assign r0_ready = gnt_r0;
    assign r1_ready = gnt_r1;

    assign sram_addr_valid = out_valid_q;
    assign sram_addr       = out_addr_q;
    assign sram_data_in    = out_data_q;
    assign sram_write_mask = out_mask_q;
    assign r0_dout_valid   = r0_dv_q;
    assign r1_dout_valid   = r1_dv_q;
    assign r0_dout         = r0_dout_q;
    assign r1_dout         = r1_dout_q;
    assign err             = err_q;

    // One-hot grant: bounded r0 priority, then round-robin, then r0 fallback
    always_comb begin
        gnt_w0 = 1'b0;
        gnt_w1 = 1'b0;
        gnt_r0 = 1'b0;
        gnt_r1 = 1'b0;
        if (reset && load_en) begin
            if (elig_r0 && (burst_q < BURST_L)) begin
                gnt_r0 = 1'b1;
            end else begin
                case (rr_q)
                    RR_W0: begin
                        if (elig_w0)      gnt_w0 = 1'b1;
                        else if (elig_w1) gnt_w1 = 1'b1;
                        else if (elig_r1) gnt_r1 = 1'b1;
                    end
                    RR_W1: begin
                        if (elig_w1)      gnt_w1 = 1'b1;
                        else if (elig_r1) gnt_r1 = 1'b1;
                        else if (elig_w0) gnt_w0 = 1'b1;
                    end
                    default: begin
                        if (elig_r1)      gnt_r1 = 1'b1;
                        else if (elig_w0) gnt_w0 = 1'b1;
                        else if (elig_w1) gnt_w1 = 1'b1;
                    end
                endcase
                if (!(gnt_w0 || gnt_w1 || gnt_r1)) begin
                    gnt_r0 = elig_r0;
                end
            end
        end
    end

    // Next state for output stage, tag FIFO, arbitration and return path
    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        burst_d     = burst_q;
        rr_d        = rr_q;

        // A zero-mask write is handshaken but leaves the stage empty.
        if (load_en) begin
            out_valid_d = 1'b0;
            if (gnt_w0 && (w0_din[53:50] != 4'h0)) begin
                out_valid_d = 1'b1;
                out_mask_d  = w0_din[53:50];
                out_addr_d  = w0_din[49:32];
                out_data_d  = w0_din[31:0];
            end else if (gnt_w1 && (w1_din[53:50] != 4'h0)) begin
                out_valid_d = 1'b1;
                out_mask_d  = w1_din[53:50];
                out_addr_d  = w1_din[49:32];
                out_data_d  = w1_din[31:0];
            end else if (gnt_r0) begin
                out_valid_d = 1'b1;
                out_mask_d  = '0;
                out_addr_d  = r0_addr;
                out_data_d  = '0;
            end else if (gnt_r1) begin
                out_valid_d = 1'b1;
                out_mask_d  = '0;
                out_addr_d  = r1_addr;
                out_data_d  = '0;
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW + 1)'(1);
        else if (!push && pop) count_d = count_q - (AW + 1)'(1);

        if (gnt_r0) begin
            if (others_valid) burst_d = (burst_q != '1) ? burst_q + BW'(1) : burst_q;
            else              burst_d = '0;
        end else if (gnt_w0 || gnt_w1 || gnt_r1) begin
            burst_d = '0;
        end

        if (gnt_w0)      rr_d = RR_W1;
        else if (gnt_w1) rr_d = RR_R1;
        else if (gnt_r1) rr_d = RR_W0;

        r0_dv_d   = pop && !pop_tag;
        r1_dv_d   = pop && pop_tag;
        r0_dout_d = (pop && !pop_tag) ? sram_data_out : r0_dout_q;
        r1_dout_d = (pop && pop_tag)  ? sram_data_out : r1_dout_q;
        err_d     = err_q || (sram_data_out_valid && (count_q == '0));
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            burst_q     <= '0;
            rr_q        <= RR_W0;
            r0_dv_q     <= 1'b0;
            r1_dv_q     <= 1'b0;
            r0_dout_q   <= '0;
            r1_dout_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            burst_q     <= burst_d;
            rr_q        <= rr_d;
            r0_dv_q     <= r0_dv_d;
            r1_dv_q     <= r1_dv_d;
            r0_dout_q   <= r0_dout_d;
            r1_dout_q   <= r1_dout_d;
            err_q       <= err_d;
        end
    end

    // Tag storage; contents are only meaningful between push and pop
    always_ff @(posedge clock) begin
        if (push) tag_mem_q[wr_ptr_q] <= gnt_r1;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: a cycle-level reference model
// predicts grants, SRAM requests and routed read returns; a monitor process
// pops expected requests/returns as the DUT presents them.
module tb_sram_req_arbiter;

    localparam int TAG_DEPTH = 8;
    localparam int R0_BURST  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        w0_valid = 1'b0, w1_valid = 1'b0, r0_valid = 1'b0, r1_valid = 1'b0;
    logic        w0_ready, w1_ready, r0_ready, r1_ready;
    logic [53:0] w0_din = '0, w1_din = '0;
    logic [17:0] r0_addr = '0, r1_addr = '0;
    logic        r0_dout_valid, r1_dout_valid;
    logic [31:0] r0_dout, r1_dout;
    logic        sram_addr_valid;
    logic        sram_ready = 1'b0;
    logic [17:0] sram_addr;
    logic [31:0] sram_data_in;
    logic [3:0]  sram_write_mask;
    logic [31:0] sram_data_out = '0;
    logic        sram_data_out_valid = 1'b0;
    logic        err;

    sram_req_arbiter #(.TAG_DEPTH(TAG_DEPTH), .R0_BURST(R0_BURST)) dut (
        .clock(clock), .reset(reset),
        .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_din(w0_din),
        .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_din(w1_din),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
        .r0_dout_valid(r0_dout_valid), .r0_dout(r0_dout),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
        .r1_dout_valid(r1_dout_valid), .r1_dout(r1_dout),
        .sram_addr_valid(sram_addr_valid), .sram_ready(sram_ready),
        .sram_addr(sram_addr), .sram_data_in(sram_data_in),
        .sram_write_mask(sram_write_mask), .sram_data_out(sram_data_out),
        .sram_data_out_valid(sram_data_out_valid), .err(err)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // Requester index: 0 = w0, 1 = w1, 2 = r1, 3 = r0 (0..2 is the round-robin ring)
    bit          drv_v [4];
    logic [53:0] drv_din [2];
    logic [17:0] drv_raddr [2];
    bit          drv_sready = 1'b1;
    bit          spurious = 1'b0;
    int          lat = 3;

    int          ret_due [$];
    logic [53:0] sb [$];
    logic [32:0] ret_exp [$];
    int          m_tags [$];
    int          m_occ = 0, m_burst = 0, m_rr = 0;
    bit          m_outv = 1'b0, m_err = 1'b0;
    int          last_gnt = -1;
    logic [3:0]  last_rdy = '0;

    logic [53:0] mon_e;
    logic [32:0] mon_r;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void fail_now(string name);
        n_chk++;
        $display("FAIL %s: got unexpected event, required none (cycle %0d)", name, cyc);
    endfunction

    function automatic logic [53:0] rnd_w(bit allow_zero);
        logic [3:0] m;
        m = 4'($urandom_range(1, 15));
        if (allow_zero && ($urandom_range(0, 7) == 0)) m = 4'h0;
        return {m, 18'($urandom), 32'($urandom)};
    endfunction

    function automatic void model_clear();
        sb.delete(); ret_exp.delete(); m_tags.delete(); ret_due.delete();
        m_occ = 0; m_burst = 0; m_rr = 0; m_outv = 1'b0; m_err = 1'b0;
        for (int k = 0; k < 4; k++) drv_v[k] = 1'b0;
    endfunction

    task automatic zero_pins();
        w0_valid = 0; w1_valid = 0; r0_valid = 0; r1_valid = 0;
        sram_data_out_valid = 0; sram_ready = 0;
    endtask

    // One clock cycle: apply inputs, predict the grant, compare, update model.
    task automatic cycle();
        logic [3:0] exp_rdy;
        int g, id, due, idx;
        bit le, pop;
        bit el [4];
        @(negedge clock);
        cyc++;
        w0_valid = drv_v[0]; w1_valid = drv_v[1]; r1_valid = drv_v[2]; r0_valid = drv_v[3];
        w0_din = drv_din[0]; w1_din = drv_din[1];
        r0_addr = drv_raddr[0]; r1_addr = drv_raddr[1];
        sram_ready = drv_sready;
        sram_data_out = $urandom;
        sram_data_out_valid = 1'b0;
        if (spurious) begin
            sram_data_out_valid = 1'b1;
            spurious = 1'b0;
        end else if (ret_due.size() > 0 && ret_due[0] == cyc) begin
            void'(ret_due.pop_front());
            sram_data_out_valid = 1'b1;
        end
        #2;
        pop = sram_data_out_valid && (m_occ > 0);
        le  = !m_outv || sram_ready;
        el[0] = drv_v[0];
        el[1] = drv_v[1];
        el[2] = drv_v[2] && ((m_occ < TAG_DEPTH) || pop);
        el[3] = drv_v[3] && ((m_occ < TAG_DEPTH) || pop);
        g = -1;
        if (le) begin
            if (el[3] && m_burst < R0_BURST) g = 3;
            else begin
                for (int k = 0; k < 3; k++) begin
                    idx = (m_rr + k) % 3;
                    if (g < 0 && el[idx]) g = idx;
                end
                if (g < 0 && el[3]) g = 3;
            end
        end
        exp_rdy  = (g < 0) ? 4'h0 : 4'(1 << g);
        last_rdy = {r0_ready, r1_ready, w1_ready, w0_ready};
        last_gnt = g;
        chk("ready", last_rdy, exp_rdy);
        chk("addr_valid", sram_addr_valid, m_outv);
        chk("err", err, m_err);

        // Controller side: accepted reads return in order after lat cycles.
        if (sram_addr_valid && sram_ready && sram_write_mask == 4'h0) begin
            due = cyc + lat;
            if (ret_due.size() > 0 && due <= ret_due[$]) due = ret_due[$] + 1;
            ret_due.push_back(due);
        end

        if (le) begin
            m_outv = 1'b0;
            if (g == 0 || g == 1) begin
                if (drv_din[g][53:50] != 4'h0) begin
                    sb.push_back(drv_din[g]);
                    m_outv = 1'b1;
                end
            end else if (g >= 2) begin
                id = (g == 2) ? 1 : 0;
                sb.push_back({4'h0, drv_raddr[id], 32'h0});
                m_tags.push_back(id);
                m_occ++;
                m_outv = 1'b1;
            end
        end
        if (g == 3) m_burst = (drv_v[0] || drv_v[1] || drv_v[2]) ? m_burst + 1 : 0;
        else if (g >= 0) m_burst = 0;
        if (g >= 0 && g <= 2) m_rr = (g + 1) % 3;
        if (sram_data_out_valid) begin
            if (pop) begin
                m_occ--;
                id = m_tags.pop_front();
                ret_exp.push_back({1'(id), sram_data_out});
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_ctl"}, {w0_ready, w1_ready, r0_ready, r1_ready,
                            r0_dout_valid, r1_dout_valid, sram_addr_valid, err}, 0);
        chk({tag, "_sram"}, {sram_addr, sram_write_mask, sram_data_in}, 0);
        chk({tag, "_dout"}, {r0_dout, r1_dout}, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        zero_pins();
        model_clear();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset_vals("rst");
    endtask

    task automatic drain();
        int k;
        k = 0;
        for (int i = 0; i < 4; i++) drv_v[i] = 1'b0;
        drv_sready = 1'b1;
        while ((sb.size() > 0 || ret_exp.size() > 0 || ret_due.size() > 0 || m_outv) && k < 200) begin
            cycle();
            k++;
        end
        cycle();
        cycle();
        chk("drain_sb", sb.size(), 0);
        chk("drain_ret", ret_exp.size(), 0);
    endtask

    task automatic refresh(int g);
        if (g == 0 || g == 1) drv_din[g] = rnd_w(1'b0);
        else if (g == 2) drv_raddr[1] = 18'($urandom);
        else if (g == 3) drv_raddr[0] = 18'($urandom);
    endtask

    // Monitor: pop and compare whenever the DUT presents a request or return
    always @(negedge clock) begin
        #3;
        if (reset) begin
            if (sram_addr_valid && sram_ready) begin
                if (sb.size() == 0) fail_now("sram_req_extra");
                else begin
                    mon_e = sb.pop_front();
                    chk("sram_req", {sram_write_mask, sram_addr, sram_data_in}, mon_e);
                end
            end
            if (r0_dout_valid && r1_dout_valid) fail_now("dout_both");
            else if (r0_dout_valid || r1_dout_valid) begin
                if (ret_exp.size() == 0) fail_now("dout_extra");
                else begin
                    mon_r = ret_exp.pop_front();
                    chk("dout_route", r1_dout_valid ? {1'b1, r1_dout} : {1'b0, r0_dout}, mon_r);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt [4];
        int gc [$];
        for (int k = 0; k < 2; k++) begin
            drv_din[k] = '0;
            drv_raddr[k] = '0;
        end
        for (int k = 0; k < 4; k++) drv_v[k] = 1'b0;

        // w0 alone streams addresses 0,1,2
        do_reset();
        drv_sready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                drv_din[0] = {4'($urandom_range(1, 15)), 18'(i), 32'($urandom)};
                drv_v[0] = 1'b1;
            end else begin
                drv_v[0] = 1'b0;
            end
            cycle();
            if (i < 3) chk("a_w0_ready", last_rdy[0], 1'b1);
            if (i > 0) chk("a_addr_seq", {sram_addr_valid, sram_addr}, {1'b1, 18'(i - 1)});
        end
        drain();

        // w0, w1, r1 continuously valid: fair rotation starting at w0
        do_reset();
        lat = 3;
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        drv_din[0] = rnd_w(1'b0); drv_din[1] = rnd_w(1'b0); drv_raddr[1] = 18'($urandom);
        drv_v[0] = 1'b1; drv_v[1] = 1'b1; drv_v[2] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (i == 0) chk("b_first_w0", last_rdy, 4'b0001);
            for (int k = 0; k < 4; k++) if (last_rdy[k]) cnt[k]++;
            refresh(last_gnt);
        end
        chk("b_w0_share", cnt[0], 10);
        chk("b_w1_share", cnt[1], 10);
        chk("b_r1_share", cnt[2], 10);
        drain();

        // r0 and w0 continuously valid: r0 x4 then w0
        do_reset();
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        drv_din[0] = rnd_w(1'b0); drv_raddr[0] = 18'($urandom);
        drv_v[0] = 1'b1; drv_v[3] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            cycle();
            for (int k = 0; k < 4; k++) if (last_rdy[k]) cnt[k]++;
            refresh(last_gnt);
        end
        chk("c_r0_count", cnt[3], 20);
        chk("c_w0_count", cnt[0], 5);
        drain();

        // Fill the tag FIFO with long return latency; 9th read waits for a pop
        do_reset();
        lat = 12;
        drv_raddr[0] = 18'($urandom); drv_raddr[1] = 18'($urandom);
        drv_v[2] = 1'b1; drv_v[3] = 1'b1;
        for (int i = 0; i < 40 && gc.size() < 9; i++) begin
            cycle();
            if (last_rdy[2] || last_rdy[3]) gc.push_back(cyc);
            refresh(last_gnt);
        end
        chk("d_nine_reads", gc.size(), 9);
        if (gc.size() >= 9) begin
            chk("d_eight_b2b", gc[7] - gc[0], 7);
            chk("d_ninth_at_pop", gc[8] - gc[0], 1 + 12);
        end
        drain();
        lat = 3;

        // w1 with mask 0: handshake only, pointer moves on to r1
        do_reset();
        drv_din[0] = rnd_w(1'b0); drv_v[0] = 1'b1;
        cycle();
        drv_v[0] = 1'b0;
        drv_din[1] = {4'h0, 18'($urandom), 32'($urandom)}; drv_v[1] = 1'b1;
        cycle();
        chk("e_w1_ready", last_rdy, 4'b0010);
        drv_v[1] = 1'b0;
        drv_din[0] = rnd_w(1'b0); drv_v[0] = 1'b1;
        drv_raddr[1] = 18'($urandom); drv_v[2] = 1'b1;
        cycle();
        chk("e_rr_r1", last_rdy, 4'b0100);
        chk("e_no_req", sram_addr_valid, 1'b0);
        drain();

        // Spurious return sets sticky err; reset mid-burst clears everything
        do_reset();
        spurious = 1'b1;
        cycle();
        cycle();
        chk("f_err_set", err, 1'b1);
        drv_din[0] = rnd_w(1'b0); drv_din[1] = rnd_w(1'b0);
        drv_raddr[0] = 18'($urandom); drv_raddr[1] = 18'($urandom);
        for (int k = 0; k < 4; k++) drv_v[k] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            refresh(last_gnt);
        end
        chk("f_err_sticky", err, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        zero_pins();
        model_clear();
        @(posedge clock);
        #1;
        check_reset_vals("f_mid");
        @(negedge clock);
        reset = 1'b1;

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (!drv_v[k] && $urandom_range(0, 2) == 0) begin
                    drv_v[k] = 1'b1;
                    if (k < 2) drv_din[k] = rnd_w(1'b1);
                    else if (k == 2) drv_raddr[1] = 18'($urandom);
                    else drv_raddr[0] = 18'($urandom);
                end
            end
            drv_sready = ($urandom_range(0, 3) != 0);
            lat = $urandom_range(1, 6);
            cycle();
            if (last_gnt >= 0) drv_v[last_gnt] = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
